// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB) with a bounded memory wait.
// Optional macro MCU_UPPER_IMM_EN adds LUI/AUIPC support; otherwise they decode as illegal.
module multicycle_control #(
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               Branch,
    output logic               ALUSrc,
    output logic               MemToReg,
    output logic               PCWrite,
    output logic               busy,
    output logic               illegal,
    output logic               timeout
);

    localparam int unsigned     CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        C_ILLEGAL,
        C_RTYPE,
        C_ITYPE,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_UIMM
    } cls_t;

    function automatic cls_t classify(input logic [6:0] op);
        cls_t c;
        case (op)
            7'b0110011: c = C_RTYPE;
            7'b0010011: c = C_ITYPE;
            7'b0000011: c = C_LOAD;
            7'b0100011: c = C_STORE;
            7'b1100011: c = C_BRANCH;
`ifdef MCU_UPPER_IMM_EN
            7'b0110111,
            7'b0010111: c = C_UIMM;
`endif
            default:    c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    state_t           state_q, state_d;
    logic [6:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cls_t             cls_c, cls_next_c;

    logic       instr_ready_q, instr_ready_d;
    logic       busy_q, busy_d;
    logic       illegal_q, illegal_d;
    logic [1:0] aluop_q, aluop_d;
    logic       memread_q, memread_d;
    logic       memwrite_q, memwrite_d;
    logic       regwrite_q, regwrite_d;
    logic       branch_q, branch_d;
    logic       alusrc_q, alusrc_d;
    logic       memtoreg_q, memtoreg_d;
    logic       pcwrite_q, pcwrite_d;

    logic store_done_c;
    logic wait_expired_c;

    assign cls_c = classify(opcode_q);

    // Next state, then the registered controls belonging to the state being entered.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        cnt_d         = cnt_q;
        instr_ready_d = 1'b0;
        busy_d        = 1'b0;
        illegal_d     = 1'b0;
        aluop_d       = 2'b00;
        memread_d     = 1'b0;
        memwrite_d    = 1'b0;
        regwrite_d    = 1'b0;
        branch_d      = 1'b0;
        alusrc_d      = 1'b0;
        memtoreg_d    = 1'b0;
        pcwrite_d     = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    opcode_d = opcode;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (cls_c == C_ILLEGAL) ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
                case (cls_c)
                    C_RTYPE, C_ITYPE, C_UIMM: state_d = S_WB;
                    C_LOAD, C_STORE: begin
                        state_d = S_MEM;
                        cnt_d   = '0;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (cls_c == C_LOAD) ? S_WB : S_FETCH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        cls_next_c = classify(opcode_d);

        case (state_d)
            S_FETCH: begin
                instr_ready_d = 1'b1;
            end
            S_DECODE: begin
                busy_d    = 1'b1;
                illegal_d = (cls_next_c == C_ILLEGAL);
            end
            S_EXEC: begin
                busy_d = 1'b1;
                case (cls_next_c)
                    C_RTYPE: aluop_d = 2'b10;
                    C_ITYPE: begin
                        aluop_d  = 2'b10;
                        alusrc_d = 1'b1;
                    end
                    C_LOAD, C_STORE: begin
                        aluop_d  = 2'b00;
                        alusrc_d = 1'b1;
                    end
                    C_BRANCH: begin
                        aluop_d   = 2'b01;
                        branch_d  = 1'b1;
                        pcwrite_d = 1'b1;
                    end
                    C_UIMM: begin
                        aluop_d  = 2'b11;
                        alusrc_d = 1'b1;
                    end
                    default: aluop_d = 2'b00;
                endcase
            end
            S_MEM: begin
                busy_d     = 1'b1;
                alusrc_d   = 1'b1;
                memread_d  = (cls_next_c == C_LOAD);
                memwrite_d = (cls_next_c == C_STORE);
            end
            S_WB: begin
                busy_d     = 1'b1;
                regwrite_d = 1'b1;
                pcwrite_d  = 1'b1;
                memtoreg_d = (cls_next_c == C_LOAD);
            end
            default: begin
                instr_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            opcode_q      <= '0;
            cnt_q         <= '0;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            illegal_q     <= 1'b0;
            aluop_q       <= 2'b00;
            memread_q     <= 1'b0;
            memwrite_q    <= 1'b0;
            regwrite_q    <= 1'b0;
            branch_q      <= 1'b0;
            alusrc_q      <= 1'b0;
            memtoreg_q    <= 1'b0;
            pcwrite_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            cnt_q         <= cnt_d;
            instr_ready_q <= instr_ready_d;
            busy_q        <= busy_d;
            illegal_q     <= illegal_d;
            aluop_q       <= aluop_d;
            memread_q     <= memread_d;
            memwrite_q    <= memwrite_d;
            regwrite_q    <= regwrite_d;
            branch_q      <= branch_d;
            alusrc_q      <= alusrc_d;
            memtoreg_q    <= memtoreg_d;
            pcwrite_q     <= pcwrite_d;
        end
    end

    // Store completion and wait expiry must react to mem_ready within the same MEM cycle.
    assign store_done_c   = (state_q == S_MEM) && (cls_c == C_STORE) && mem_ready;
    assign wait_expired_c = (state_q == S_MEM) && !mem_ready && (cnt_q == CNT_LAST);

    assign instr_ready = instr_ready_q;
    assign busy        = busy_q;
    assign illegal     = illegal_q;
    assign ALUOp       = ALUOP_W'(aluop_q);
    assign MemRead     = memread_q;
    assign MemWrite    = memwrite_q;
    assign RegWrite    = regwrite_q;
    assign Branch      = branch_q;
    assign ALUSrc      = alusrc_q;
    assign MemToReg    = memtoreg_q;
    assign PCWrite     = pcwrite_q | store_done_c;
    assign timeout     = wait_expired_c;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a phase-level model queues the per-cycle
// control vector expected after each handshake; a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int unsigned TO = 15;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;

    typedef struct packed {
        logic       rdy;
        logic       busy;
        logic       ill;
        logic       to;
        logic [1:0] aluop;
        logic       mr;
        logic       mw;
        logic       rw;
        logic       br;
        logic       as;
        logic       m2r;
        logic       pcw;
    } ctl_t;

    typedef struct {
        ctl_t  v;
        string tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [6:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic [1:0] ALUOp;
    logic       MemRead, MemWrite, RegWrite, Branch, ALUSrc, MemToReg, PCWrite;
    logic       busy, illegal, timeout;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    multicycle_control #(.ALUOP_W(2), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
        .mem_ready(mem_ready), .ALUOp(ALUOp),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .Branch(Branch),
        .ALUSrc(ALUSrc), .MemToReg(MemToReg), .PCWrite(PCWrite),
        .busy(busy), .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic ctl_t sample();
        ctl_t s;
        s.rdy = instr_ready; s.busy = busy; s.ill = illegal; s.to = timeout;
        s.aluop = ALUOp; s.mr = MemRead; s.mw = MemWrite; s.rw = RegWrite;
        s.br = Branch; s.as = ALUSrc; s.m2r = MemToReg; s.pcw = PCWrite;
        return s;
    endfunction

    function automatic ctl_t idle_vec();
        ctl_t s = '0;
        s.rdy = 1'b1;
        return s;
    endfunction

    task automatic check(input string name, input ctl_t got, input ctl_t exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // 0 illegal, 1 R, 2 I, 3 load, 4 store, 5 branch, 6 upper-immediate
    function automatic int kind(input logic [6:0] op);
        case (op)
            OP_R:  return 1;
            OP_I:  return 2;
            OP_LD: return 3;
            OP_ST: return 4;
            OP_BR: return 5;
`ifdef MCU_UPPER_IMM_EN
            OP_LUI, OP_AUI: return 6;
`endif
            default: return 0;
        endcase
    endfunction

    function automatic int mem_cycles(input int ready_at);
        return (ready_at != 0) ? ready_at : int'(TO);
    endfunction

    // Queues the expected per-cycle sequence; returns the number of busy cycles.
    function automatic int model_push(input logic [6:0] op, input int ready_at);
        int   k = kind(op);
        int   n = 0;
        ctl_t v;
        v = '0; v.busy = 1'b1; v.ill = (k == 0);
        sb.push_back('{v, $sformatf("op%02h_decode", op)}); n++;
        if (k != 0) begin
            v = '0; v.busy = 1'b1;
            case (k)
                1: v.aluop = 2'b10;
                2: begin v.aluop = 2'b10; v.as = 1'b1; end
                3, 4: begin v.aluop = 2'b00; v.as = 1'b1; end
                5: begin v.aluop = 2'b01; v.br = 1'b1; v.pcw = 1'b1; end
                default: begin v.aluop = 2'b11; v.as = 1'b1; end
            endcase
            sb.push_back('{v, $sformatf("op%02h_exec", op)}); n++;
            if (k == 3 || k == 4) begin
                for (int m = 1; m <= mem_cycles(ready_at); m++) begin
                    v = '0; v.busy = 1'b1; v.as = 1'b1;
                    v.mr = (k == 3); v.mw = (k == 4);
                    v.pcw = (k == 4) && (m == ready_at);
                    v.to = (ready_at == 0) && (m == int'(TO));
                    sb.push_back('{v, $sformatf("op%02h_mem%0d", op, m)}); n++;
                end
            end
            if (k == 1 || k == 2 || k == 6 || (k == 3 && ready_at != 0)) begin
                v = '0; v.busy = 1'b1; v.rw = 1'b1; v.pcw = 1'b1; v.m2r = (k == 3);
                sb.push_back('{v, $sformatf("op%02h_wb", op)}); n++;
            end
        end
        sb.push_back('{idle_vec(), $sformatf("op%02h_ret", op)});
        return n;
    endfunction

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, sample(), e.v);
        end
    end

    // Entered and left at posedge+1; opcode and instr_valid are scrambled while busy.
    task automatic run_instr(input logic [6:0] op, input int ready_at, input int gap);
        int n;
        int k = kind(op);
        repeat (gap) begin @(posedge clk); #1; end
        instr_valid = 1'b1;
        opcode      = op;
        mem_ready   = 1'($urandom);
        @(posedge clk);
        n = model_push(op, ready_at);
        #1;
        for (int c = 1; c <= n; c++) begin
            instr_valid = 1'($urandom);
            opcode      = 7'($urandom);
            if ((k == 3 || k == 4) && c >= 3 && c <= 2 + mem_cycles(ready_at))
                mem_ready = ((c - 2) == ready_at);
            else
                mem_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
    endtask

    function automatic int pick_ready();
        int r = int'($urandom_range(0, TO + 3));
        return (r >= 1 && r <= int'(TO)) ? r : 0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", checks);
        $fatal(1);
    end

    initial begin
        logic [6:0] ops [9];
        ctl_t       v;
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUI, 7'b1111111, 7'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", sample(), idle_vec());
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_instr(OP_R, 0, 0);
        run_instr(OP_LD, 3, 0);
        run_instr(OP_ST, 0, 1);
        run_instr(7'b1111111, 0, 0);
        run_instr(OP_LUI, 0, 0);
        run_instr(OP_AUI, 0, 2);
        run_instr(OP_BR, 0, 0);
        run_instr(OP_I, 0, 0);
        run_instr(OP_ST, 1, 0);
        run_instr(OP_LD, 0, 0);
        run_instr(OP_ST, int'(TO), 0);

        for (int i = 0; i < 200; i++) begin
            int sel = int'($urandom_range(0, 8));
            logic [6:0] op = (sel == 8) ? 7'($urandom) : ops[sel];
            run_instr(op, pick_ready(), int'($urandom_range(0, 2)));
        end

        // Asynchronous reset while a load waits in MEM.
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL sb_drain_pre_reset: got %0d pending expected 0", sb.size());
        instr_valid = 1'b1;
        opcode      = OP_LD;
        mem_ready   = 1'b0;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        v = '0; v.busy = 1'b1; v.as = 1'b1; v.mr = 1'b1;
        check("pre_reset_mem", sample(), v);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_mem", sample(), idle_vec());
        @(negedge clk);
        check("held_in_reset", sample(), idle_vec());
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_instr(OP_R, 0, 0);
        run_instr(OP_LD, 2, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL sb_drain_final: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL provide parameter ALUOP_W, default 2, giving the ALUOp output width (legal values >= 2).
REQ-002 The block SHALL provide parameter MEM_TIMEOUT, default 15, giving the maximum number of MEM-state cycles spent waiting for mem_ready (legal range 1..255).
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port instr_valid  input  1  a new opcode is presented.
REQ-006 Port instr_ready  output  1  the block accepts an opcode this cycle.
REQ-007 Port opcode  input  7  RISC-V opcode field, sampled only on the instr_valid/instr_ready handshake.
REQ-008 Port mem_ready  input  1  data memory has completed the current access.
REQ-009 Port ALUOp  output  ALUOP_W  ALU operation class; bits above bit 1 are always 0.
REQ-010 Ports MemRead, MemWrite, RegWrite, Branch, ALUSrc, MemToReg, PCWrite  output  1 each  datapath controls.
REQ-011 Port busy  output  1  high in every state except FETCH.
REQ-012 Port illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-013 Port timeout  output  1  one-cycle pulse on memory wait expiry.

Function
REQ-014 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM and WB; instr_ready SHALL be 1 only in FETCH.
REQ-015 FETCH: on instr_valid=1, the opcode SHALL be latched into an internal register and the FSM SHALL move to DECODE; otherwise it SHALL hold.
REQ-016 DECODE: an unsupported opcode SHALL assert illegal for that cycle and return to FETCH with no datapath control asserted; a supported opcode SHALL go to EXEC.
REQ-017 EXEC controls: R-type 0110011 -> ALUOp=10, ALUSrc=0; I-type 0010011 -> ALUOp=10, ALUSrc=1; load 0000011 / store 0100011 -> ALUOp=00, ALUSrc=1; branch 1100011 -> ALUOp=01, ALUSrc=0, Branch=1, PCWrite=1.
REQ-018 EXEC next state: R/I -> WB; load/store -> MEM; branch -> FETCH.
REQ-019 MEM: ALUSrc=1 SHALL be held, with MemRead=1 for a load or MemWrite=1 for a store, every cycle until mem_ready=1.
REQ-020 MEM with mem_ready=1: a load SHALL go to WB; a store SHALL assert PCWrite=1 in that cycle and go to FETCH.
REQ-021 An internal wait counter SHALL clear on entry to MEM; if mem_ready is still 0 after MEM_TIMEOUT MEM cycles, timeout SHALL pulse in that cycle and the FSM SHALL go to FETCH with no RegWrite and no PCWrite.
REQ-022 WB SHALL assert RegWrite=1 and PCWrite=1 for one cycle (MemToReg=1 for a load, 0 otherwise), then go to FETCH.
REQ-023 Latency from handshake to return to FETCH: R/I 3 cycles, branch 2, store 2+N, load 3+N, where N is the number of MEM cycles (>=1).
REQ-024 Any control not listed for the current state SHALL be 0; controls SHALL be decoded from the latched opcode, never from the live opcode input.

Reset
REQ-025 rst_n=0 SHALL, asynchronously and at any point including mid-instruction, force FETCH, clear the latched opcode and wait counter, and drive every output to 0 except instr_ready, which SHALL be 1 (busy=0).
REQ-026 After rst_n deasserts, the first handshake SHALL be accepted on the first rising clk edge with instr_valid=1.

Configuration
REQ-027 With macro MCU_UPPER_IMM_EN defined, LUI 0110111 and AUIPC 0010111 SHALL be supported: EXEC drives ALUOp=11, ALUSrc=1, then the FSM goes to WB (MemToReg=0).
REQ-028 Without MCU_UPPER_IMM_EN, LUI and AUIPC SHALL be treated as illegal in DECODE.

Verification
REQ-029 R-type 0110011 handshake -> DECODE, EXEC (ALUOp=10, ALUSrc=0), WB (RegWrite=1, PCWrite=1), FETCH; 3 cycles.
REQ-030 Load 0000011 with mem_ready asserted on the 3rd MEM cycle -> MemRead=1 for 3 cycles, then WB with RegWrite=1 and MemToReg=1.
REQ-031 Store 0100011 with mem_ready held 0 and MEM_TIMEOUT=15 -> MemWrite=1 for 15 cycles, timeout pulse on the 15th, return to FETCH, RegWrite never 1.
REQ-032 Opcode 1111111 -> illegal pulse in DECODE, all controls 0, back in FETCH on the next cycle; with the macro undefined, 0110111 also produces an illegal pulse.
REQ-033 rst_n pulsed low during MEM of a load -> all outputs 0 and instr_ready=1 immediately, before the next clk edge.
REQ-034 Branch 1100011 -> EXEC with Branch=1, ALUOp=01 and PCWrite=1, then FETCH; opcode changed mid-instruction has no effect on the controls.
